// File: rtl/fft_pkg.sv
// fft_pkg: shared rounding-mode encodings, pipeline latency and the round/saturate helper
package fft_pkg;
  typedef enum logic [1:0] {
    RND_TRUNC  = 2'd0,
    RND_HALFUP = 2'd1,
    RND_CONV   = 2'd2,
    RND_RSVD   = 2'd3
  } rnd_mode_e;

  localparam int LATENCY = 4;
  localparam int MAXW = 128;

  // Shift right by 'shift' with the selected rounding, then clamp to a signed out_width range.
  // Any mode other than truncate/half-up rounds convergently.
  function automatic logic signed [MAXW-1:0] rnd_sat(
    input logic signed [MAXW-1:0] value,
    input int shift,
    input int out_width,
    input logic [1:0] mode
  );
    logic signed [MAXW-1:0] fl, rem, half, r, hi, lo;
    logic up;
    fl = value >>> shift;
    rem = value - (fl <<< shift);
    half = MAXW'(1) <<< (shift - 1);
    up = (rem > half) || (rem == half && fl[0]);
    r = (mode == RND_TRUNC) ? fl :
        (mode == RND_HALFUP) ? (value + half) >>> shift :
        fl + $signed({{(MAXW-1){1'b0}}, up});
    hi = (MAXW'(1) <<< (out_width - 1)) - MAXW'(1);
    lo = -hi - MAXW'(1);
    return (r > hi) ? hi : (r < lo) ? lo : r;
  endfunction
endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: combinational round + saturate of one product component
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int IN_W  = 44,
  parameter int SHIFT = 17,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  d,
  input  logic [1:0]              mode,
  output logic signed [OUT_W-1:0] q,
  output logic                    ovf
);
  logic signed [MAXW-1:0] s, u;

  // saturated result vs. the same rounding with an effectively unbounded range flags overflow
  always_comb begin
    s = rnd_sat(MAXW'(d), SHIFT, OUT_W, mode);
    u = rnd_sat(MAXW'(d), SHIFT, MAXW - 1, mode);
    q = s[OUT_W-1:0];
    ovf = s != u;
  end
endmodule

// File: rtl/fft_cmul.sv
// fft_cmul: pipelined 3-multiply complex twiddle multiplier with rounding, saturation and conj mode
module fft_cmul
  import fft_pkg::*;
#(
  parameter int IN_WIDTH     = 24,
  parameter int OUT_WIDTH    = 24,
  parameter int TW_WIDTH     = 18,
  parameter int N            = 1024,
  parameter int SATCNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        srst_n,
  input  logic                        ce_i,
  input  logic                        valid_i,
  input  logic [$clog2(N)-1:0]        ctr_i,
  input  logic signed [IN_WIDTH-1:0]  x_re_i,
  input  logic signed [IN_WIDTH-1:0]  x_im_i,
  input  logic signed [TW_WIDTH-1:0]  w_re_i,
  input  logic signed [TW_WIDTH-1:0]  w_im_i,
  input  logic                        conj_i,
  input  logic [1:0]                  rnd_mode_i,
  output logic                        valid_o,
  output logic [$clog2(N)-1:0]        ctr_o,
  output logic signed [OUT_WIDTH-1:0] z_re_o,
  output logic signed [OUT_WIDTH-1:0] z_im_o,
  output logic                        ovf_o,
  output logic [SATCNT_WIDTH-1:0]     sat_cnt_o,
  input  logic                        sat_clr_i
);
  localparam int CW  = $clog2(N);
  localparam int TW1 = TW_WIDTH + 1;
  localparam int PW  = IN_WIDTH + TW_WIDTH + 2;

  logic v1, v2, v3;
  logic [CW-1:0] t1, t2, t3;
  logic signed [IN_WIDTH-1:0] a1, b1, a2, b2;
  logic signed [TW_WIDTH-1:0] c1, c2;
  logic signed [TW1-1:0] d1, d2;
  logic signed [PW-1:0] f2, r3, i3;
  logic signed [OUT_WIDTH-1:0] zr, zi;
  logic ovr, ovi;

  // datapath: capture (conj folded into d), f = c*(a-b), then R = b(c-d)+f and I = a(c+d)-f
  always_ff @(posedge clk)
    if (ce_i) begin
      a1 <= x_re_i;
      b1 <= x_im_i;
      c1 <= w_re_i;
      d1 <= conj_i ? -TW1'(w_im_i) : TW1'(w_im_i);
      t1 <= ctr_i;
      a2 <= a1;
      b2 <= b1;
      c2 <= c1;
      d2 <= d1;
      t2 <= t1;
      f2 <= PW'(c1) * (PW'(a1) - PW'(b1));
      r3 <= PW'(b2) * (PW'(c2) - PW'(d2)) + f2;
      i3 <= PW'(a2) * (PW'(c2) + PW'(d2)) - f2;
      t3 <= t2;
    end

  fft_round_sat #(.IN_W(PW), .SHIFT(TW_WIDTH - 1), .OUT_W(OUT_WIDTH)) u_rs_re (
    .d(r3), .mode(rnd_mode_i), .q(zr), .ovf(ovr)
  );

  fft_round_sat #(.IN_W(PW), .SHIFT(TW_WIDTH - 1), .OUT_W(OUT_WIDTH)) u_rs_im (
    .d(i3), .mode(rnd_mode_i), .q(zi), .ovf(ovi)
  );

  // valid pipeline and output register; reset drops everything in flight
  always_ff @(posedge clk)
    if (!srst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      valid_o <= 1'b0;
      ovf_o <= 1'b0;
      ctr_o <= '0;
      z_re_o <= '0;
      z_im_o <= '0;
    end else if (ce_i) begin
      v1 <= valid_i;
      v2 <= v1;
      v3 <= v2;
      valid_o <= v3;
      ovf_o <= ovr | ovi;
      ctr_o <= t3;
      z_re_o <= zr;
      z_im_o <= zi;
    end

  // sticky saturation event counter; clear wins over increment
  always_ff @(posedge clk)
    if (!srst_n || sat_clr_i) sat_cnt_o <= '0;
    else if (ce_i && valid_o && ovf_o && ~&sat_cnt_o) sat_cnt_o <= sat_cnt_o + SATCNT_WIDTH'(1);
endmodule

// File: tb/tb_fft_cmul.sv
// tb_fft_cmul: scoreboard bench for fft_cmul against a real-arithmetic reference model
module tb_fft_cmul;
  import fft_pkg::*;

  localparam int IW = 24;
  localparam int OW = 24;
  localparam int TW = 18;
  localparam int CW = 10;
  localparam int SW = 16;
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW - 1));

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  logic ce_i = 1'b1;
  logic valid_i = 1'b0;
  logic [CW-1:0] ctr_i = '0;
  logic signed [IW-1:0] x_re_i = '0, x_im_i = '0;
  logic signed [TW-1:0] w_re_i = '0, w_im_i = '0;
  logic conj_i = 1'b0;
  logic [1:0] rnd_mode_i = 2'd2;
  logic sat_clr_i = 1'b0;
  logic valid_o, ovf_o;
  logic [CW-1:0] ctr_o;
  logic signed [OW-1:0] z_re_o, z_im_o;
  logic [SW-1:0] sat_cnt_o;

  fft_cmul #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TW_WIDTH(TW), .N(1 << CW), .SATCNT_WIDTH(SW)) dut (
    .clk(clk), .srst_n(srst_n), .ce_i(ce_i), .valid_i(valid_i), .ctr_i(ctr_i),
    .x_re_i(x_re_i), .x_im_i(x_im_i), .w_re_i(w_re_i), .w_im_i(w_im_i),
    .conj_i(conj_i), .rnd_mode_i(rnd_mode_i), .valid_o(valid_o), .ctr_o(ctr_o),
    .z_re_o(z_re_o), .z_im_o(z_im_o), .ovf_o(ovf_o), .sat_cnt_o(sat_cnt_o), .sat_clr_i(sat_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    logic ovf;
    logic [CW-1:0] ctr;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t e, cur;
  int checks = 0, errors = 0, en_cnt = 0, tag = 0;
  longint a, b, c, d, pre, pim, m_sat = 0;
  logic o1, o2, m_valid = 1'b0, m_ovf = 1'b0, e_rst, e_ce, e_clr;
  logic [59:0] snap;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // exact product scaled by 2^-(TW-1), rounded as a real number, then clamped
  function automatic longint rs(input longint v, input logic [1:0] m, output logic o);
    real x, f, fr;
    longint r, rl;
    x = real'(v) / real'(longint'(1) << (TW - 1));
    f = $floor(x);
    fr = x - f;
    rl = longint'(f);
    if (m == 2'd0) r = rl;
    else if (m == 2'd1) r = longint'($floor(x + 0.5));
    else r = (fr > 0.5) ? rl + 1 : (fr < 0.5) ? rl : ((rl % 2 == 0) ? rl : rl + 1);
    o = (r > OMAX) || (r < OMIN);
    return (r > OMAX) ? OMAX : (r < OMIN) ? OMIN : r;
  endfunction

  // stimulus side: every accepted sample pushes its expected result and due enabled-edge
  always @(posedge clk)
    if (!srst_n) q.delete();
    else if (ce_i) begin
      en_cnt++;
      if (valid_i) begin
        a = x_re_i;
        b = x_im_i;
        c = w_re_i;
        d = conj_i ? -longint'(w_im_i) : longint'(w_im_i);
        pre = a * c - b * d;
        pim = a * d + b * c;
        e.re = rs(pre, rnd_mode_i, o1);
        e.im = rs(pim, rnd_mode_i, o2);
        e.ovf = o1 | o2;
        e.ctr = ctr_i;
        e.due = en_cnt + LATENCY - 1;
        q.push_back(e);
      end
    end

  // monitor side: pops and compares whenever the model says an output is due
  always @(posedge clk) begin
    e_rst = !srst_n;
    e_ce = ce_i;
    e_clr = sat_clr_i;
    if (e_rst || e_clr) m_sat = 0;
    else if (e_ce && m_valid && m_ovf && m_sat != (longint'(1) << SW) - 1) m_sat++;
    #1;
    if (e_rst) begin
      m_valid = 1'b0;
      m_ovf = 1'b0;
      chk("rst_valid", longint'(valid_o), 0);
      chk("rst_out", longint'({z_re_o, z_im_o, ctr_o, ovf_o}), 0);
    end else if (e_ce) begin
      m_valid = q.size() > 0 && q[0].due == en_cnt;
      chk("valid_o", longint'(valid_o), longint'(m_valid));
      if (m_valid) begin
        cur = q.pop_front();
        m_ovf = cur.ovf;
        chk("z_re", longint'(z_re_o), cur.re);
        chk("z_im", longint'(z_im_o), cur.im);
        chk("ovf", longint'(ovf_o), longint'(cur.ovf));
        chk("ctr", longint'(ctr_o), longint'(cur.ctr));
      end else m_ovf = 1'b0;
    end else chk("stall_hold", longint'({valid_o, z_re_o, z_im_o, ctr_o, ovf_o}), longint'(snap));
    chk("sat_cnt", longint'(sat_cnt_o), m_sat);
    snap = {valid_o, z_re_o, z_im_o, ctr_o, ovf_o};
  end

  task automatic step(input logic v, input int xr, input int xi, input int wr, input int wi,
                      input logic cj, input logic [1:0] m, input logic ce = 1'b1, input logic clr = 1'b0);
    valid_i = v;
    x_re_i = IW'(xr);
    x_im_i = IW'(xi);
    w_re_i = TW'(wr);
    w_im_i = TW'(wi);
    conj_i = cj;
    rnd_mode_i = m;
    ce_i = ce;
    sat_clr_i = clr;
    ctr_i = CW'(tag);
    tag++;
    @(negedge clk);
  endtask

  task automatic flush(input logic [1:0] m);
    repeat (6) step(1'b0, 0, 0, 0, 0, 1'b0, m);
  endtask

  task automatic rnd_step(input logic [1:0] m, input logic ce, input logic clr);
    int xr, xi, wr, wi;
    xr = ($urandom % 8 == 0) ? -8388608 : int'($urandom);
    xi = ($urandom % 8 == 0) ? 8388607 : int'($urandom);
    wr = ($urandom % 8 == 0) ? -131072 : int'($urandom);
    wi = ($urandom % 8 == 0) ? -131072 : int'($urandom);
    step($urandom % 4 != 0, xr, xi, wr, wi, $urandom % 2 == 1, m, ce, clr);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    srst_n = 1'b1;
    step(1'b1, 1000, -2000, 131071, 0, 1'b0, 2'd2);
    flush(2'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1000, 0, 0, 131071, i[0], 2'd2);
    flush(2'd2);
    for (int m = 0; m < 3; m++) begin
      step(1'b1, 3, 0, 65536, 0, 1'b0, 2'(m));
      step(1'b1, 5, 0, 65536, 0, 1'b0, 2'(m));
      step(1'b1, -3, 0, 65536, 0, 1'b0, 2'(m));
      flush(2'(m));
    end
    step(1'b1, -8388608, 0, -131072, 0, 1'b0, 2'd2);
    flush(2'd2);
    step(1'b1, -8388608, 0, -131072, 0, 1'b0, 2'd2, 1'b1, 1'b1);
    flush(2'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) rnd_step(2'd2, 1'b0, 1'b0);
      step(1'b1, int'($urandom), int'($urandom), int'($urandom), int'($urandom), $urandom % 2 == 1, 2'd2);
    end
    flush(2'd2);
    repeat (3) step(1'b1, int'($urandom), int'($urandom), int'($urandom), int'($urandom), 1'b0, 2'd1);
    srst_n = 1'b0;
    step(1'b0, 0, 0, 0, 0, 1'b0, 2'd1);
    srst_n = 1'b1;
    flush(2'd1);
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 250; i++) rnd_step(2'(m), $urandom % 8 != 0, $urandom % 64 == 0);
      flush(2'(m));
    end
    chk("drain", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
